wide_shift_sequencer: RTL and testbench

- Multi-cycle controller that performs a W-bit shift (W = 4*NIBBLES) by streaming the operand one nibble per cycle through the team's 4-bit arithmetic shifter.
- Acts as both the upstream stage and the downstream stage of that shifter:
  - drives the shifter's A and B inputs;
  - consumes its X output (shifted nibble) and Y output (bits shifted out);
  - chains Y into the adjacent nibble.
- Sits between the ALU operand bus (valid/ready request) and the ALU result mux (valid/ready response).

---
 rtl/wide_shift_sequencer.sv | 145 ++++++++++++++
 tb/tb_wide_shift_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wide_shift_sequencer.sv
// Streams a W-bit shift one nibble per cycle through an external 4-bit shifter.
// Optional result flags (rsp_zero, rsp_last_out) are enabled by WIDE_SHIFT_FLAGS_EN.
module wide_shift_sequencer #(
  parameter int NIBBLES = 4,
  parameter int AMT_W   = $clog2(4*NIBBLES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4*NIBBLES-1:0]   req_op,
  input  logic [AMT_W-1:0]       req_amt,
  input  logic                   req_dir,
  input  logic                   req_arith,
  output logic [3:0]             shf_a,
  output logic [3:0]             shf_b,
  input  logic [3:0]             shf_x,
  input  logic [3:0]             shf_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
`ifdef WIDE_SHIFT_FLAGS_EN
  output logic                   rsp_zero,
  output logic                   rsp_last_out,
`endif
  output logic [4*NIBBLES-1:0]   rsp_data
);

  localparam int W   = 4*NIBBLES;
  localparam int NW  = AMT_W-2;
  localparam int AW1 = AMT_W+1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    op;
  logic            dir;
  logic            fill;
  logic [NW-1:0]   nib_off;
  logic [1:0]      bit_off;
  logic [2:0]      cnt;
  logic [3:0]      carry;

  logic [2:0]      i_idx;
  logic [4:0]      j_idx;
  logic [3:0]      src;
  logic [W-1:0]    result_next;
  logic            fill_in;

  assign fill_in = req_dir & req_arith & req_op[W-1];

  // Out-of-range source indices wrap far above NIBBLES, so they never match
  // and the fill nibble is selected.
  always_comb begin
    i_idx = dir ? (3'(NIBBLES-1) - cnt) : cnt;
    j_idx = dir ? ({2'b00, i_idx} + 5'(nib_off)) : ({2'b00, i_idx} - 5'(nib_off));
    src   = {4{fill}};
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (j_idx == 5'(k)) src = op[4*k +: 4];
    end
    result_next = rsp_data;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (i_idx == 3'(k)) result_next[4*k +: 4] = shf_x | carry;
    end
  end

  assign shf_a = (state == RUN) ? src : '0;
  assign shf_b = (state == RUN) ? {1'b0, bit_off, dir} : '0;

`ifdef WIDE_SHIFT_FLAGS_EN
  logic last_in;
  logic last_q;

  always_comb begin
    last_in = 1'b0;
    for (int unsigned k = 0; k < W; k++) begin
      if (req_amt != '0) begin
        if (!req_dir && (({1'b0, req_amt} + AW1'(k)) == AW1'(W))) last_in = req_op[k];
        if ( req_dir && ({1'b0, req_amt} == AW1'(k+1)))          last_in = req_op[k];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= '0;
      dir       <= 1'b0;
      fill      <= 1'b0;
      nib_off   <= '0;
      bit_off   <= '0;
      cnt       <= '0;
      carry     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
`ifdef WIDE_SHIFT_FLAGS_EN
      last_q       <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_last_out <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op        <= req_op;
            dir       <= req_dir;
            fill      <= fill_in;
            nib_off   <= req_amt[AMT_W-1:2];
            bit_off   <= req_amt[1:0];
            cnt       <= '0;
            carry     <= (req_dir && fill_in) ? ~(4'hF >> req_amt[1:0]) : '0;
            req_ready <= 1'b0;
            state     <= RUN;
`ifdef WIDE_SHIFT_FLAGS_EN
            last_q    <= last_in;
`endif
          end
        end
        RUN: begin
          rsp_data <= result_next;
          carry    <= shf_y;
          cnt      <= cnt + 3'd1;
          if (cnt == 3'(NIBBLES-1)) begin
            state     <= DONE;
            rsp_valid <= 1'b1;
`ifdef WIDE_SHIFT_FLAGS_EN
            rsp_zero     <= (result_next == '0);
            rsp_last_out <= last_q;
`endif
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_shift_sequencer.sv
// Directed bench for wide_shift_sequencer (NIBBLES=4) with a behavioural 4-bit shifter.
module tb_wide_shift_sequencer;

  localparam int NIBBLES = 4;
  localparam int W       = 16;
  localparam int AMT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [W-1:0]     req_op = '0;
  logic [AMT_W-1:0] req_amt = '0;
  logic             req_dir = 1'b0;
  logic             req_arith = 1'b0;
  logic [3:0]       shf_a, shf_b, shf_x, shf_y;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [W-1:0]     rsp_data;
`ifdef WIDE_SHIFT_FLAGS_EN
  logic             rsp_zero, rsp_last_out;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wide_shift_sequencer #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_amt(req_amt), .req_dir(req_dir), .req_arith(req_arith),
    .shf_a(shf_a), .shf_b(shf_b), .shf_x(shf_x), .shf_y(shf_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
`ifdef WIDE_SHIFT_FLAGS_EN
    .rsp_zero(rsp_zero), .rsp_last_out(rsp_last_out),
`endif
    .rsp_data(rsp_data)
  );

  // 4-bit shifter: B = {fill, amount[1:0], dir}; Y carries the bits pushed out.
  logic [7:0] shf_tmp;
  always_comb begin
    if (!shf_b[0]) begin
      shf_tmp = {4'b0000, shf_a} << shf_b[2:1];
      shf_x   = shf_tmp[3:0];
      shf_y   = shf_tmp[7:4];
    end else begin
      shf_tmp = {shf_a, 4'b0000} >> shf_b[2:1];
      shf_x   = shf_tmp[7:4];
      shf_y   = shf_tmp[3:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic [W-1:0] op, input logic [AMT_W-1:0] amt,
                      input logic dir, input logic arith);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_op = op; req_amt = amt; req_dir = dir; req_arith = arith; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check({tag, "_ready_drop"}, 32'(req_ready), 32'd0);
  endtask

  // Cycles counted from the accept cycle (inclusive) to the first cycle with rsp_valid.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] op, input logic [AMT_W-1:0] amt,
                        input logic dir, input logic arith, input logic [W-1:0] exp);
    int cyc;
    send(tag, op, amt, dir, arith);
    wait_rsp(cyc);
    check({tag, "_lat"}, 32'(cyc), 32'(NIBBLES+1));
    check({tag, "_data"}, 32'(rsp_data), 32'(exp));
    check({tag, "_ready_busy"}, 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid_clr"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    check({tag, "_data_keep"}, 32'(rsp_data), 32'(exp));
  endtask

  initial begin
    int cyc;
    logic seen;

    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_shf_a",     32'(shf_a),     32'd0);
    check("rst_shf_b",     32'(shf_b),     32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op("l1234_3", 16'h1234, 4'd3, 1'b0, 1'b0, 16'h91A0);
    run_op("l1234_4", 16'h1234, 4'd4, 1'b0, 1'b0, 16'h2340);
    run_op("l8001_1", 16'h8001, 4'd1, 1'b0, 1'b0, 16'h0002);
    run_op("ra8000_5", 16'h8000, 4'd5, 1'b1, 1'b1, 16'hFC00);
    run_op("rlF00F_15", 16'hF00F, 4'd15, 1'b1, 1'b0, 16'h0001);
    run_op("ra7FFF_15", 16'h7FFF, 4'd15, 1'b1, 1'b1, 16'h0000);
    run_op("la1234_9", 16'h1234, 4'd9, 1'b0, 1'b1, 16'h6800);

    // Zero shift with back-pressure and an ignored request pulse.
    rsp_ready = 1'b0;
    send("hold", 16'h5A3C, 4'd0, 1'b0, 1'b0);
    wait_rsp(cyc);
    check("hold_lat", 32'(cyc), 32'(NIBBLES+1));
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        @(negedge clk);
        req_op = 16'hFFFF; req_amt = 4'd1; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("hold_data",  32'(rsp_data),  32'h5A3C);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_valid", 32'(rsp_valid), 32'd0);
    check("hold_release_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1 seen |= rsp_valid;
    end
    check("hold_no_extra_rsp", 32'(seen), 32'd0);

    // Reset in the middle of RUN.
    send("rstmid", 16'hABCD, 4'd6, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("rstmid_shf_a", 32'(shf_a), 32'hC);
    check("rstmid_shf_b", 32'(shf_b), 32'h4);
    rst_n = 1'b0;
    #1;
    check("rstmid_ready", 32'(req_ready), 32'd1);
    check("rstmid_valid", 32'(rsp_valid), 32'd0);
    check("rstmid_data",  32'(rsp_data),  32'd0);
    check("rstmid_shf_a0", 32'(shf_a), 32'd0);
    check("rstmid_shf_b0", 32'(shf_b), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 seen |= rsp_valid;
    end
    check("rstmid_no_rsp", 32'(seen), 32'd0);
    run_op("post_rst", 16'h0001, 4'd1, 1'b0, 1'b0, 16'h0002);

`ifdef WIDE_SHIFT_FLAGS_EN
    send("flag_l", 16'h8000, 4'd1, 1'b0, 1'b0);
    wait_rsp(cyc);
    check("flag_l_data", 32'(rsp_data), 32'd0);
    check("flag_l_zero", 32'(rsp_zero), 32'd1);
    check("flag_l_last", 32'(rsp_last_out), 32'd1);
    @(posedge clk);
    send("flag_r", 16'h0002, 4'd1, 1'b1, 1'b0);
    wait_rsp(cyc);
    check("flag_r_data", 32'(rsp_data), 32'd1);
    check("flag_r_zero", 32'(rsp_zero), 32'd0);
    check("flag_r_last", 32'(rsp_last_out), 32'd0);
    @(posedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
